status_led_arbiter: RTL and testbench

//  Shares one board status LED between NREQ indication sources (link up, rx error, activity, etc.).

---
 rtl/status_led_arbiter_pkg.sv | 9 +
 rtl/status_led_arbiter_divider.sv | 19 +
 rtl/status_led_arbiter.sv | 83 ++++++++
 tb/tb_status_led_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/status_led_arbiter_pkg.sv
// status_led_arbiter_pkg: state encodings and standard LED patterns shared by the status LED arbiter
package status_led_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHOW = 1'b1} state_t;
  localparam logic [7:0] PAT_SOLID = 8'hFF;
  localparam logic [7:0] PAT_SLOW  = 8'hF0;
  localparam logic [7:0] PAT_FAST  = 8'hAA;
  localparam logic [7:0] PAT_BLIP  = 8'h01;
  localparam logic [7:0] PAT_OFF   = 8'h00;
endpackage

// File: rtl/status_led_arbiter_divider.sv
// led_tick_divider: pattern step rate divider, one tick every DIV enabled cycles, held at zero by clr
module led_tick_divider #(
  parameter int DIV = 6250000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(DIV - 1);
  // count while enabled, wrap after the terminal count, park at zero while cleared
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/status_led_arbiter.sv
// status_led_arbiter: shares one status LED between NREQ sources, playing the winner's 8-step pattern; STATUS_LED_ROUND_ROBIN_EN selects round-robin instead of fixed priority
module status_led_arbiter
  import status_led_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int TICK_DIV = 6250000,
  parameter int PAT_LEN  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_pattern,
  output logic              led,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(PAT_LEN);
  state_t state, state_nx;
  logic [7:0] pat;
  logic [SW-1:0] step;
  logic [IW-1:0] win;
  logic tick, boundary, load;

  // first requester found when searching upward from start, wrapping around
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r, input logic [IW-1:0] start);
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (r[(int'(start) + k) % NREQ]) pick = IW'((int'(start) + k) % NREQ);
  endfunction

`ifdef STATUS_LED_ROUND_ROBIN_EN
  logic [IW-1:0] rr;
  // pointer moves just past each source that is granted
  always_ff @(posedge clk or posedge rst)
    if (rst) rr <= '0;
    else if (load) rr <= int'(win) == NREQ - 1 ? '0 : win + 1'b1;
  assign win = pick(req, rr);
`else
  assign win = pick(req, IW'(0));
`endif

  led_tick_divider #(.DIV(TICK_DIV)) u_div (
    .clk (clk),
    .rst (rst),
    .clr (!busy),
    .en  (busy),
    .tick(tick)
  );

  assign busy     = state == ST_SHOW;
  assign boundary = tick && step == SW'(PAT_LEN - 1);
  assign load     = |req && (!busy || boundary);

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_nx;

  // arbitration only happens from idle or at the end of a full pattern
  always_comb state_nx = load ? ST_SHOW : boundary ? ST_IDLE : state;

  // latch the winner's pattern and step through it, one bit per tick
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant <= '0;
      pat   <= PAT_OFF;
      step  <= '0;
      led   <= 1'b0;
    end else if (load) begin
      grant <= NREQ'(1) << win;
      pat   <= req_pattern[8*int'(win) +: 8];
      step  <= '0;
      led   <= req_pattern[8*int'(win)];
    end else if (boundary) begin
      grant <= '0;
      step  <= '0;
      led   <= 1'b0;
    end else if (tick) begin
      step  <= step + 1'b1;
      led   <= pat[step + 1'b1];
    end
endmodule

// File: tb/tb_status_led_arbiter.sv
// tb_status_led_arbiter: directed stimulus with a cycle-count reference model and literal spot checks
module tb_status_led_arbiter;
  import status_led_arbiter_pkg::*;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req = '0;
  logic [31:0] req_pattern = '0;
  logic led, busy;
  logic [3:0] grant;
  int nvec = 0;
  int nerr = 0;

  status_led_arbiter #(.NREQ(4), .TICK_DIV(TD), .PAT_LEN(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_pattern(req_pattern),
    .led(led), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // reference: a pattern occupies 8*TD cycles; led is the pattern bit for cycle/TD
  bit m_busy = 0;
  int m_src = 0;
  int m_cyc = 0;
  int m_rr = 0;
  logic [7:0] m_pat = '0;

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_src = 0; m_cyc = 0; m_rr = 0;
    end else begin
      if (m_busy) begin
        m_cyc++;
        if (m_cyc == 8 * TD) m_busy = 0;
      end
      if (!m_busy && |req) begin
`ifdef STATUS_LED_ROUND_ROBIN_EN
        m_src = first_from(req, m_rr);
        m_rr = (m_src + 1) % 4;
`else
        m_src = first_from(req, 0);
`endif
        m_busy = 1;
        m_cyc = 0;
        m_pat = req_pattern[8*m_src +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_led", 32'(led), 32'(m_busy ? m_pat[m_cyc / TD] : 1'b0));
      chk("model_grant", 32'(grant), 32'(m_busy ? 4'b0001 << m_src : 4'b0000));
      chk("model_busy", 32'(busy), 32'(m_busy));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    cyc(1);
  endtask

  logic [7:0] fast;
  logic [3:0] exp_g [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(2);
    rst = 1'b0;
    cyc(1);
    // reset asserted during step 3 of a solid pattern
    req = 4'b0001;
    req_pattern[7:0] = PAT_SOLID;
    cyc(1);
    cyc(13);
    @(negedge clk);
    chk("t1_busy_before", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t1_led_rst", 32'(led), 32'd0);
    chk("t1_grant_rst", 32'(grant), 32'd0);
    chk("t1_busy_rst", 32'(busy), 32'd0);
    req = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("t1_idle_after", 32'(busy), 32'd0);
    cyc(1);
    // one-cycle request from source 1 with the fast pattern
    fast = PAT_FAST;
    req = 4'b0010;
    req_pattern[15:8] = PAT_FAST;
    cyc(1);
    req = '0;
    @(negedge clk);
    chk("t2_grant", 32'(grant), 32'h2);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      if (i % 4 == 2) chk("t2_led_step", 32'(led), 32'(fast[i / 4]));
    end
    @(negedge clk);
    chk("t2_busy_end", 32'(busy), 32'd0);
    chk("t2_grant_end", 32'(grant), 32'd0);
    cyc(1);
    // higher priority arrives mid-pattern and waits for the boundary
    req = 4'b1000;
    req_pattern[31:24] = PAT_SOLID;
    cyc(1);
    cyc(8);
    req = 4'b0001;
    req_pattern[7:0] = PAT_BLIP;
    @(negedge clk);
    repeat (23) @(negedge clk);
    chk("t3_grant_last", 32'(grant), 32'h8);
    @(negedge clk);
    chk("t3_grant_switch", 32'(grant), 32'h1);
    chk("t3_busy_switch", 32'(busy), 32'd1);
    chk("t3_led_switch", 32'(led), 32'd1);
    cyc(1);
    req = '0;
    wait_idle();
    // two sources held across three patterns
`ifdef STATUS_LED_ROUND_ROBIN_EN
    exp_g = '{4'b0010, 4'b0100, 4'b0010};
`else
    exp_g = '{4'b0010, 4'b0010, 4'b0010};
`endif
    req = 4'b0110;
    req_pattern[15:8] = PAT_SLOW;
    req_pattern[23:16] = PAT_SLOW;
    cyc(1);
    @(negedge clk);
    chk("t4_grant_0", 32'(grant), 32'(exp_g[0]));
    repeat (32) @(negedge clk);
    chk("t4_grant_1", 32'(grant), 32'(exp_g[1]));
    repeat (32) @(negedge clk);
    chk("t4_grant_2", 32'(grant), 32'(exp_g[2]));
    cyc(1);
    req = '0;
    wait_idle();
    // pattern and request changed mid-pattern: latched pattern plays out
    req = 4'b0100;
    req_pattern[23:16] = PAT_SLOW;
    cyc(1);
    cyc(8);
    req_pattern[23:16] = 8'h0F;
    req = '0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t6_led_step3", 32'(led), 32'd0);
    repeat (8) @(negedge clk);
    chk("t6_led_step5", 32'(led), 32'd1);
    chk("t6_grant", 32'(grant), 32'h4);
    cyc(1);
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
